defuse_sequencer: RTL and testbench

DEFUSE_SEQUENCER -- requirements
Module: defuse_sequencer

---
 rtl/defuse_sequencer.sv | 162 ++++++++++++++++
 tb/tb_defuse_sequencer.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/defuse_sequencer.sv
// Flood-fill defuse sequencer: queues clicked cells and their zero-count
// neighbours, then issues one defuse pulse per not-yet-defused cell.
module defuse_sequencer #(
    parameter int FIFO_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] level,
    input  logic       click_valid,
    input  logic [4:0] click_x,
    input  logic [4:0] click_y,
    input  logic       explode,
    output logic [4:0] look_x,
    output logic [4:0] look_y,
    input  logic       look_mine,
    input  logic       look_defused,
    input  logic [3:0] look_cnt,
    output logic       defuse,
    output logic [4:0] defuse_ind_x,
    output logic [4:0] defuse_ind_y,
    output logic       busy,
    output logic       overflow
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_INC = 1;

    typedef enum logic [2:0] {IDLE, POP, CHECK, DEFUSE, EXPAND} state_e;

    state_e            state_q, state_d;
    logic [AW:0]       wptr_q, rptr_q;
    logic [9:0]        fifo_q [FIFO_DEPTH];
    logic [4:0]        cur_x_q, cur_y_q;
    logic [2:0]        k_q;
    logic              defuse_q, ovf_q;
    logic [4:0]        dind_x_q, dind_y_q;
    logic [1:0]        level_q;

    logic [4:0]        n_size;
    logic              empty, full, abort, click_ok, push, pop, nb_in, ovf_set;
    logic signed [5:0] dx, dy, nx, ny, n_s;
    logic [9:0]        push_data;

    always_comb begin
        case (level)
            2'd1:    n_size = 5'd8;
            2'd2:    n_size = 5'd10;
            2'd3:    n_size = 5'd16;
            default: n_size = 5'd0;
        endcase
    end

    // Neighbour scan order: row above, same row, row below; left to right.
    always_comb begin
        case (k_q)
            3'd0, 3'd3, 3'd5: dx = -6'sd1;
            3'd2, 3'd4, 3'd7: dx = 6'sd1;
            default:          dx = 6'sd0;
        endcase
        if (k_q < 3'd3)      dy = -6'sd1;
        else if (k_q < 3'd5) dy = 6'sd0;
        else                 dy = 6'sd1;
    end

    assign n_s   = $signed({1'b0, n_size});
    assign nx    = $signed({1'b0, cur_x_q}) + dx;
    assign ny    = $signed({1'b0, cur_y_q}) + dy;
    assign nb_in = (nx >= 6'sd1) && (nx <= n_s) && (ny >= 6'sd1) && (ny <= n_s);

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign click_ok = click_valid && !busy && (level != 2'd0) && !explode &&
                      (click_x >= 5'd1) && (click_x <= n_size) &&
                      (click_y >= 5'd1) && (click_y <= n_size);
    // A level change mid-flood invalidates the board, so it aborts like a mine hit.
    assign abort     = explode || (busy && (level != level_q));
    assign push      = !abort && (click_ok || (state_q == EXPAND && nb_in && !full));
    assign ovf_set   = !abort && (state_q == EXPAND) && nb_in && full;
    assign pop       = !abort && (state_q == POP) && !empty;
    assign push_data = click_ok ? {click_x, click_y} : {nx[4:0], ny[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (click_ok) state_d = POP;
            POP:     state_d = empty ? IDLE : CHECK;
            CHECK:   state_d = look_defused ? POP : DEFUSE;
            DEFUSE:  state_d = (look_cnt == 4'd0 && !look_mine) ? EXPAND : POP;
            EXPAND:  if (k_q == 3'd7) state_d = POP;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Out-of-board neighbours show the centre cell so no illegal index leaves the block.
    always_comb begin
        busy   = (state_q != IDLE) || !empty;
        look_x = 5'd0;
        look_y = 5'd0;
        case (state_q)
            CHECK, DEFUSE: begin
                look_x = cur_x_q;
                look_y = cur_y_q;
            end
            EXPAND: begin
                look_x = nb_in ? nx[4:0] : cur_x_q;
                look_y = nb_in ? ny[4:0] : cur_y_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cur_x_q  <= 5'd0;
            cur_y_q  <= 5'd0;
            k_q      <= 3'd0;
            defuse_q <= 1'b0;
            dind_x_q <= 5'd0;
            dind_y_q <= 5'd0;
            ovf_q    <= 1'b0;
            level_q  <= 2'd0;
        end else begin
            level_q  <= level;
            defuse_q <= (state_q == CHECK) && !look_defused && !abort;
            if (state_q == CHECK && !look_defused) begin
                dind_x_q <= cur_x_q;
                dind_y_q <= cur_y_q;
            end
            if (abort) begin
                rptr_q <= wptr_q;
            end else begin
                if (push) wptr_q <= wptr_q + PTR_INC;
                if (pop) begin
                    {cur_x_q, cur_y_q} <= fifo_q[rptr_q[AW-1:0]];
                    rptr_q             <= rptr_q + PTR_INC;
                end
            end
            k_q <= (state_q == EXPAND) ? k_q + 3'd1 : 3'd0;
            if (click_ok)     ovf_q <= 1'b0;
            else if (ovf_set) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q[AW-1:0]] <= push_data;
    end

    assign defuse       = defuse_q;
    assign defuse_ind_x = dind_x_q;
    assign defuse_ind_y = dind_y_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_defuse_sequencer.sv
// Bench for defuse_sequencer: board model drives look inputs, a queue-based
// flood reference predicts the ordered defuse pulses and the overflow flag.
module tb_defuse_sequencer;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } cell_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] level;
    logic       click_valid;
    logic [4:0] click_x, click_y;
    logic       explode;
    logic [4:0] look_x, look_y;
    logic       look_mine, look_defused;
    logic [3:0] look_cnt;
    logic       defuse;
    logic [4:0] defuse_ind_x, defuse_ind_y;
    logic       busy, overflow;

    bit         b_mine [0:31][0:31];
    bit         b_def  [0:31][0:31];
    logic [3:0] b_cnt  [0:31][0:31];

    cell_t exp_q[$];
    cell_t got_q[$];
    bit    exp_ovf;
    bit    bad_look;
    int    n_chk = 0;
    int    n_fail = 0;

    defuse_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .level(level), .click_valid(click_valid),
        .click_x(click_x), .click_y(click_y), .explode(explode),
        .look_x(look_x), .look_y(look_y), .look_mine(look_mine),
        .look_defused(look_defused), .look_cnt(look_cnt), .defuse(defuse),
        .defuse_ind_x(defuse_ind_x), .defuse_ind_y(defuse_ind_y),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign look_mine    = b_mine[look_x][look_y];
    assign look_defused = b_def[look_x][look_y];
    assign look_cnt     = b_cnt[look_x][look_y];

    function automatic int nsize(input int l);
        case (l)
            1:       return 8;
            2:       return 10;
            3:       return 16;
            default: return 0;
        endcase
    endfunction

    function automatic bit pulses_match();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (exp_q[i]) if (got_q[i] != exp_q[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                if (defuse) begin
                    got_q.push_back({defuse_ind_x, defuse_ind_y});
                    b_def[defuse_ind_x][defuse_ind_y] = 1'b1;
                end
                if (int'(look_x) > nsize(int'(level)) || int'(look_y) > nsize(int'(level)) ||
                    ((look_x == 5'd0) != (look_y == 5'd0)))
                    bad_look = 1'b1;
            end
        end
    endtask

    task automatic clear_board(input int cntval);
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < 32; j++) begin
                b_mine[i][j] = 1'b0;
                b_def[i][j]  = 1'b0;
                b_cnt[i][j]  = cntval[3:0];
            end
    endtask

    task automatic calc_counts(input int n);
        int c;
        for (int x = 1; x <= n; x++)
            for (int y = 1; y <= n; y++) begin
                c = 0;
                for (int ddx = -1; ddx <= 1; ddx++)
                    for (int ddy = -1; ddy <= 1; ddy++)
                        if (!(ddx == 0 && ddy == 0) && x + ddx >= 1 && x + ddx <= n &&
                            y + ddy >= 1 && y + ddy <= n && b_mine[x + ddx][y + ddy])
                            c++;
                b_cnt[x][y] = c[3:0];
            end
    endtask

    // Reference flood: breadth-first with a bounded queue, defused test at pop time.
    task automatic model_run(input int lvl, input int cx, input int cy);
        int    n, x, y;
        cell_t q[$];
        cell_t c, nb;
        bit    md [0:31][0:31];
        n = nsize(lvl);
        md = b_def;
        exp_q.delete();
        exp_ovf = 1'b0;
        c.x = cx[4:0];
        c.y = cy[4:0];
        q.push_back(c);
        while (q.size() > 0) begin
            c = q.pop_front();
            if (md[c.x][c.y]) continue;
            exp_q.push_back(c);
            md[c.x][c.y] = 1'b1;
            if (b_cnt[c.x][c.y] == 4'd0 && !b_mine[c.x][c.y]) begin
                for (int ddy = -1; ddy <= 1; ddy++)
                    for (int ddx = -1; ddx <= 1; ddx++) begin
                        if (ddx == 0 && ddy == 0) continue;
                        x = int'(c.x) + ddx;
                        y = int'(c.y) + ddy;
                        if (x < 1 || x > n || y < 1 || y > n) continue;
                        if (q.size() == DEPTH) exp_ovf = 1'b1;
                        else begin
                            nb.x = x[4:0];
                            nb.y = y[4:0];
                            q.push_back(nb);
                        end
                    end
            end
        end
    endtask

    task automatic do_click(input int x, input int y);
        @(posedge clk); #1;
        click_valid = 1'b1;
        click_x = x[4:0];
        click_y = y[4:0];
        @(posedge clk); #1;
        click_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_pulses(input int cnt, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (got_q.size() >= cnt) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; level = 2'd0; click_valid = 1'b0; click_x = 5'd0; click_y = 5'd0; explode = 1'b0;
        clear_board(0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({look_x, look_y, defuse, defuse_ind_x, defuse_ind_y, busy, overflow} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {look_x, look_y, defuse, defuse_ind_x, defuse_ind_y, busy, overflow});
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({defuse, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: defuse/busy %b required 00", {defuse, busy});
        end
    endtask

    task automatic test_single();
        clear_board(2);
        level = 2'd1;
        got_q.delete();
        @(posedge clk); #1;
        click_valid = 1'b1; click_x = 5'd3; click_y = 5'd3;
        @(posedge clk); #1;
        click_valid = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({defuse, defuse_ind_x, defuse_ind_y} !== {1'b1, 5'd3, 5'd3}) begin
            n_fail++;
            $display("FAIL single_latency: defuse %b ind (%0d,%0d) required 1 (3,3)",
                     defuse, defuse_ind_x, defuse_ind_y);
        end
        @(posedge clk); #1;
        n_chk++;
        if (defuse !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b required 0", defuse); end
        @(posedge clk); #1;
        n_chk++;
        if (busy !== 1'b0 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_done: busy %b pulses %0d required 0 1", busy, got_q.size());
        end
    endtask

    task automatic test_corner();
        bit    to;
        cell_t want[4];
        want[0] = {5'd1, 5'd1}; want[1] = {5'd2, 5'd1};
        want[2] = {5'd1, 5'd2}; want[3] = {5'd2, 5'd2};
        clear_board(1);
        b_cnt[1][1] = 4'd0;
        level = 2'd1;
        got_q.delete();
        bad_look = 1'b0;
        do_click(1, 1);
        wait_idle(500, to);
        n_chk++;
        if (to || got_q.size() != 4 || got_q[0] != want[0] || got_q[1] != want[1] ||
            got_q[2] != want[2] || got_q[3] != want[3]) begin
            n_fail++;
            $display("FAIL corner_order: timeout %b pulses %0d required 4 in order (1,1)(2,1)(1,2)(2,2)",
                     to, got_q.size());
        end
        n_chk++;
        if (bad_look !== 1'b0) begin n_fail++; $display("FAIL corner_look_range: got %b required 0", bad_look); end
    endtask

    task automatic test_overflow();
        bit to;
        clear_board(0);
        level = 2'd3;
        @(posedge clk);
        bad_look = 1'b0;
        got_q.delete();
        model_run(3, 8, 8);
        do_click(8, 8);
        wait_idle(20000, to);
        n_chk++;
        if (to || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: timeout %b overflow %b required 0 1", to, overflow);
        end
        n_chk++;
        if (!pulses_match() || bad_look) begin
            n_fail++;
            $display("FAIL overflow_flood: pulses %0d required %0d bad_look %b", got_q.size(), exp_q.size(), bad_look);
        end
    endtask

    task automatic test_random();
        bit to;
        int lvl, n, cx, cy;
        for (int it = 0; it < 5; it++) begin
            lvl = $urandom_range(1, 3);
            n = nsize(lvl);
            clear_board(0);
            for (int x = 1; x <= n; x++)
                for (int y = 1; y <= n; y++) begin
                    b_mine[x][y] = ($urandom_range(0, 99) < 20);
                    b_def[x][y]  = ($urandom_range(0, 99) < 10);
                end
            calc_counts(n);
            cx = $urandom_range(1, n);
            cy = $urandom_range(1, n);
            level = lvl[1:0];
            @(posedge clk);
            bad_look = 1'b0;
            got_q.delete();
            model_run(lvl, cx, cy);
            do_click(cx, cy);
            wait_idle(20000, to);
            n_chk++;
            if (to || !pulses_match() || overflow !== exp_ovf || bad_look) begin
                n_fail++;
                $display("FAIL random_flood[%0d]: timeout %b pulses %0d required %0d ovf %b required %b bad_look %b",
                         it, to, got_q.size(), exp_q.size(), overflow, exp_ovf, bad_look);
            end
        end
    endtask

    task automatic test_explode();
        bit to;
        clear_board(0);
        level = 2'd3;
        @(posedge clk);
        got_q.delete();
        do_click(8, 8);
        wait_pulses(3, to);
        @(posedge clk); #1;
        explode = 1'b1;
        @(posedge clk); #1;
        explode = 1'b0;
        n_chk++;
        if (to || defuse !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL explode_abort: timeout %b defuse %b busy %b required 0 0 0", to, defuse, busy);
        end
        b_cnt[16][16] = 4'd2;
        b_def[16][16] = 1'b0;
        got_q.delete();
        do_click(16, 16);
        wait_idle(200, to);
        n_chk++;
        if (to || got_q.size() != 1 || got_q[0] != {5'd16, 5'd16} || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL explode_next_click: pulses %0d required 1 at (16,16) overflow %b required 0",
                     got_q.size(), overflow);
        end
    endtask

    task automatic test_ignored();
        bit to;
        clear_board(2);
        b_def[4][4] = 1'b1;
        level = 2'd1;
        @(posedge clk);
        got_q.delete();
        do_click(4, 4);
        wait_idle(50, to);
        n_chk++;
        if (to || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL defused_click: pulses %0d required 0", got_q.size());
        end
        do_click(9, 1);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL out_of_range_click: busy %b required 0", busy); end
        do_click(0, 5);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_coord_click: busy %b required 0", busy); end
        level = 2'd0;
        @(posedge clk);
        do_click(3, 3);
        repeat (4) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL level0_click: busy %b pulses %0d required 0 0", busy, got_q.size());
        end
    endtask

    task automatic test_level_change();
        bit to;
        clear_board(0);
        level = 2'd2;
        @(posedge clk);
        got_q.delete();
        do_click(5, 5);
        wait_pulses(2, to);
        @(posedge clk); #1;
        level = 2'd1;
        @(posedge clk); #1;
        n_chk++;
        if (to || busy !== 1'b0 || defuse !== 1'b0) begin
            n_fail++;
            $display("FAIL level_change_abort: timeout %b busy %b defuse %b required 0 0 0", to, busy, defuse);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_board(0);
        level = 2'd1;
        @(posedge clk);
        got_q.delete();
        do_click(4, 4);
        wait_pulses(1, to);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_chk++;
        if (to || {look_x, look_y, defuse, defuse_ind_x, defuse_ind_y, busy, overflow} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: timeout %b outputs %h required 0", to,
                     {look_x, look_y, defuse, defuse_ind_x, defuse_ind_y, busy, overflow});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_queue: busy %b pulses %0d required 0 1", busy, got_q.size());
        end
        clear_board(2);
        got_q.delete();
        do_click(6, 6);
        wait_idle(50, to);
        n_chk++;
        if (to || got_q.size() != 1 || got_q[0] != {5'd6, 5'd6}) begin
            n_fail++;
            $display("FAIL reset_mid_reuse: pulses %0d required 1 at (6,6)", got_q.size());
        end
    endtask

    initial begin
        bad_look = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_corner();
        test_overflow();
        test_random();
        test_explode();
        test_ignored();
        test_level_change();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
